// File: rtl/genesis_pad_responder.sv
// Device-side Mega Drive/Genesis gamepad model. Watches the host select line and drives the six
// multiplexed active-low pad lines from a 12-bit pressed-button vector.
// Build option: define PAD_SIX_BUTTON_EN for the 6-button pad (phase counter plus idle timer).
// Without it the block is a 3-button pad: phase is tied to 0 and X/Y/Z/mode are ignored.
`timescale 1ns/1ps
module genesis_pad_responder #(
   parameter int unsigned SYNC_STAGES    = 2,     // at least 2
   parameter int unsigned TIMEOUT_CYCLES = 75000  // idle clocks before phase returns to 0
) (
   input  logic        clock_50,
   input  logic        reset_key,
   input  logic        select_in,
   input  logic [11:0] buttons_in,
   output logic        up_z,
   output logic        down_y,
   output logic        left_x,
   output logic        right,
   output logic        a_b,
   output logic        start_c,
   output logic [2:0]  phase
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sel_s;
   logic                   sel_prev_q;
   logic [2:0]             phase_q;
   logic [11:0]            nb;
   logic [5:0]             pad_d, pad_q;

   assign sel_s = sync_q[SYNC_STAGES-1];
   assign nb    = ~buttons_in;

   // Select synchroniser; flops reset to the idle-high level so reset creates no edge.
   always_ff @(posedge clock_50 or negedge reset_key) begin
      if (!reset_key) sync_q <= '1;
      else            sync_q <= {sync_q[SYNC_STAGES-2:0], select_in};
   end

   // Delayed select for edge detection; also the select value aligned with phase_q.
   always_ff @(posedge clock_50 or negedge reset_key) begin
      if (!reset_key) sel_prev_q <= 1'b1;
      else            sel_prev_q <= sel_s;
   end

`ifdef PAD_SIX_BUTTON_EN
   localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);

   logic              sel_edge, sel_fall;
   logic [TimerW-1:0] timer_q, timer_d;
   logic [2:0]        phase_d;

   assign sel_edge = sel_s ^ sel_prev_q;
   assign sel_fall = sel_edge & ~sel_s;

   // Phase counts falling edges (saturating at 4); an edge always beats the idle timeout.
   always_comb begin
      phase_d = phase_q;
      timer_d = timer_q;
      if (sel_edge) begin
         timer_d = '0;
         if (sel_fall && phase_q != 3'd4) phase_d = phase_q + 3'd1;
      end else if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
         phase_d = 3'd0;  // timer parks at its final value until the next edge
      end else begin
         timer_d = timer_q + TimerW'(1);
      end
   end

   // Phase and idle-timer state.
   always_ff @(posedge clock_50 or negedge reset_key) begin
      if (!reset_key) begin
         phase_q <= 3'd0;
         timer_q <= '0;
      end else begin
         phase_q <= phase_d;
         timer_q <= timer_d;
      end
   end
`else
   logic unused_xyz_mode;

   assign phase_q         = 3'd0;
   assign unused_xyz_mode = ^buttons_in[11:8];
`endif

   // Pad-line mux, order {up_z, down_y, left_x, right, a_b, start_c}.
   always_comb begin
      pad_d = 6'b111111;
      if (sel_prev_q) begin
         if (phase_q == 3'd3) pad_d = {nb[10], nb[9], nb[8], nb[11], nb[5], nb[6]};
         else                 pad_d = {nb[0], nb[1], nb[2], nb[3], nb[5], nb[6]};
      end else begin
         case (phase_q)
            3'd3:    pad_d = {4'b0000, nb[4], nb[7]};  // 6-button ID
            3'd4:    pad_d = {4'b1111, nb[4], nb[7]};
            default: pad_d = {nb[0], nb[1], 2'b00, nb[4], nb[7]};
         endcase
      end
   end

   // Registered pad lines, released on reset.
   always_ff @(posedge clock_50 or negedge reset_key) begin
      if (!reset_key) pad_q <= 6'b111111;
      else            pad_q <= pad_d;
   end

   assign {up_z, down_y, left_x, right, a_b, start_c} = pad_q;
   assign phase = phase_q;

endmodule

// File: tb/tb_genesis_pad_responder.sv
// Self-checking bench for genesis_pad_responder: table of select/button vectors with a scoreboard
// queue, plus hand-written timeout-boundary and mid-sequence reset sequences.
`timescale 1ns/1ps
module tb_genesis_pad_responder;

   localparam int unsigned Sync = 2;
   localparam int unsigned Tmo  = 40;
   localparam int unsigned Lat  = Sync + 2;

   logic        clock_50   = 1'b0;
   logic        reset_key  = 1'b0;
   logic        select_in  = 1'b1;
   logic [11:0] buttons_in = 12'hFFF;
   logic        up_z, down_y, left_x, right, a_b, start_c;
   logic [2:0]  phase;
   logic [5:0]  pad;

   assign pad = {up_z, down_y, left_x, right, a_b, start_c};

   genesis_pad_responder #(
      .SYNC_STAGES   (Sync),
      .TIMEOUT_CYCLES(Tmo)
   ) dut (
      .clock_50  (clock_50),
      .reset_key (reset_key),
      .select_in (select_in),
      .buttons_in(buttons_in),
      .up_z      (up_z),
      .down_y    (down_y),
      .left_x    (left_x),
      .right     (right),
      .a_b       (a_b),
      .start_c   (start_c),
      .phase     (phase)
   );

   always #5 clock_50 = ~clock_50;

   typedef struct {
      logic        sel;
      logic [11:0] btn;
      int unsigned extra;
      logic [2:0]  ph6;
      logic [5:0]  pad6;
      logic [5:0]  pad3;
   } vec_t;

   typedef struct {
      logic [2:0] ph;
      logic [5:0] pad;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [2:0] ph6, input logic [5:0] pad6, input logic [5:0] pad3);
      exp_t e;
`ifdef PAD_SIX_BUTTON_EN
      e.ph  = ph6;
      e.pad = pad6;
`else
      e.ph  = 3'd0;
      e.pad = pad3;
      if (ph6 > 3'd4) e.ph = 3'd7;
`endif
      sb.push_back(e);
   endtask

   task automatic drive(input logic sel, input logic [11:0] btn);
      @(posedge clock_50);
      #1;
      select_in  = sel;
      buttons_in = btn;
   endtask

   task automatic settle(input int unsigned extra);
      repeat (Lat + extra) @(posedge clock_50);
      @(negedge clock_50);
   endtask

   task automatic pop_check(input string name);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = sb.pop_front();
         check({name, ".phase"}, {3'b000, phase}, {3'b000, e.ph});
         check({name, ".pad"}, pad, e.pad);
      end
   endtask

   task automatic apply(input string name, input vec_t v);
      drive(v.sel, v.btn);
      push_exp(v.ph6, v.pad6, v.pad3);
      settle(v.extra);
      pop_check(name);
   endtask

   // Holds select high for 'gap' clocks after the rising drive, then drops it.
   task automatic high_gap_low(input string name, input int unsigned gap, input logic [2:0] ph6);
      drive(1'b1, 12'h000);
      repeat (gap) @(posedge clock_50);
      #1;
      select_in = 1'b0;
      push_exp(ph6, 6'b110011, 6'b110011);
      settle(0);
      pop_check(name);
   endtask

   vec_t vecs[14];
   vec_t v;

   initial begin
      //          sel   btn      extra    ph6   pad6       pad3
      vecs[0]  = '{1'b1, 12'hFFF, 0,       3'd0, 6'b000000, 6'b000000};
      vecs[1]  = '{1'b1, 12'h021, 0,       3'd0, 6'b011101, 6'b011101};
      vecs[2]  = '{1'b0, 12'h021, 0,       3'd1, 6'b010011, 6'b010011};
      vecs[3]  = '{1'b1, 12'h021, 0,       3'd1, 6'b011101, 6'b011101};
      vecs[4]  = '{1'b1, 12'h500, 0,       3'd1, 6'b111111, 6'b111111};
      vecs[5]  = '{1'b0, 12'h500, 0,       3'd2, 6'b110011, 6'b110011};
      vecs[6]  = '{1'b1, 12'h500, 0,       3'd2, 6'b111111, 6'b111111};
      vecs[7]  = '{1'b0, 12'h500, 0,       3'd3, 6'b000011, 6'b110011};
      vecs[8]  = '{1'b1, 12'h500, 0,       3'd3, 6'b010111, 6'b111111};
      vecs[9]  = '{1'b0, 12'h500, 0,       3'd4, 6'b111111, 6'b110011};
      vecs[10] = '{1'b1, 12'h500, 0,       3'd4, 6'b111111, 6'b111111};
      vecs[11] = '{1'b0, 12'h590, 0,       3'd4, 6'b111100, 6'b110000};
      vecs[12] = '{1'b1, 12'h000, Tmo + 5, 3'd0, 6'b111111, 6'b111111};
      vecs[13] = '{1'b0, 12'h000, 0,       3'd1, 6'b110011, 6'b110011};

      // Reset held: lines released, phase 0.
      repeat (3) @(posedge clock_50);
      @(negedge clock_50);
      check("reset.pad", pad, 6'b111111);
      check("reset.phase", {3'b000, phase}, 6'd0);
      reset_key = 1'b1;

      for (int i = 0; i < 14; i++) apply($sformatf("vec%0d", i), vecs[i]);

      // Falling edge just inside the idle window counts normally (phase 1 -> 2).
      high_gap_low("edge_at_timeout", Tmo - 1, 3'd2);
      // Falling edge just past the window: phase was cleared first (phase 2 -> 0 -> 1).
      high_gap_low("edge_after_timeout", Tmo + 1, 3'd1);

      // Walk to phase 3 again, exercising the Y/Z/mode row.
      v = '{1'b1, 12'h000, 0, 3'd1, 6'b111111, 6'b111111}; apply("seq_a", v);
      v = '{1'b0, 12'h000, 0, 3'd2, 6'b110011, 6'b110011}; apply("seq_b", v);
      v = '{1'b1, 12'hE04, 0, 3'd2, 6'b110111, 6'b110111}; apply("seq_c", v);
      v = '{1'b0, 12'h000, 0, 3'd3, 6'b000011, 6'b110011}; apply("seq_d", v);
      v = '{1'b1, 12'hE04, 0, 3'd3, 6'b001011, 6'b110111}; apply("seq_e", v);

      // Asynchronous reset mid-sequence, checked before the next clock edge.
      @(negedge clock_50);
      #2;
      reset_key = 1'b0;
      #1;
      check("async_reset.pad", pad, 6'b111111);
      check("async_reset.phase", {3'b000, phase}, 6'd0);
      repeat (3) @(posedge clock_50);
      @(negedge clock_50);
      reset_key = 1'b1;

      v = '{1'b1, 12'h000, 0, 3'd0, 6'b111111, 6'b111111}; apply("post_reset_a", v);
      v = '{1'b0, 12'h000, 0, 3'd1, 6'b110011, 6'b110011}; apply("post_reset_b", v);

      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
